imem_boot_loader: RTL and testbench
===================================

// Module: imem_boot_loader
// PURPOSE
//   Boot-time sequencer for the instruction fetch stage. Receives a byte stream, assembles
//   32-bit words, and writes them into the fetch stage's instruction memory through its
//   write port (mode=10, w_addr, in_data). Holds the fetch stage in reset while loading,
//   then releases it so the PC restarts at word address 0.
// PARAMETERS
//   DEPTH    1024   instruction memory size in words; header N > DEPTH is an error
//   TIMEOUT  65535  max idle cycles between bytes in HDR/DATA before ERR; 0 disables
// PORTS
//   clk         in   1   system clock, shared with the fetch stage
//   rst         in   1   synchronous, active-high reset
//   load_req    in   1   1-cycle pulse: start a load; ignored unless state is IDLE or ERR
//   byte_valid  in   1   byte_data is valid this cycle
//   byte_data   in   8   stream byte, little-endian within each word
//   byte_ready  out  1   loader accepts a byte when byte_valid && byte_ready
//   mode        out  2   to fetch mode: 2'b00 = run, 2'b10 = write; mode[0] is always 0
//   w_addr      out  32  to fetch w_addr: word index being written
//   in_data     out  32  to fetch in_data: assembled instruction word
//   core_rst    out  1   to fetch rst; 1 holds PC/IR at 0
//   busy        out  1   1 in HDR, DATA, WRITE
//   done        out  1   1-cycle pulse when a load completes
//   err         out  1   sticky error flag; cleared by an accepted load_req or rst
// BEHAVIOUR
//   Reset: state=IDLE. All outputs 0: mode=00, w_addr=0, in_data=0, core_rst=0,
//     byte_ready=0, busy=0, done=0, err=0. Byte index, word count, word index and
//     timeout counter all 0.
//   Handshake: a byte is taken on any rising edge with byte_valid && byte_ready.
//     Byte k (k=0..3) fills bits [8k+7:8k]. byte_ready is 1 only in HDR and DATA.
//   IDLE: core_rst=0, mode=00. load_req -> HDR; core_rst=1 from the next cycle.
//   HDR: collect 4 bytes into N (word count). On the 4th byte:
//     N==0 -> DONE; N>DEPTH -> ERR; otherwise -> DATA with word index=0.
//   DATA: collect 4 bytes. On the 4th byte -> WRITE; in_data=word, w_addr=index.
//   WRITE: exactly 1 cycle with mode=10; byte_ready=0; in_data and w_addr held stable.
//     Then index+1. If index+1==N -> DONE, else -> DATA.
//     Bytes are never lost: the source must wait while byte_ready=0.
//   DONE: 1 cycle with done=1, core_rst=1, mode=00 -> IDLE. core_rst falls in IDLE, so
//     the fetch stage starts fetching from PC=0 on the following edge.
//   ERR: err=1, core_rst=1, mode=00, byte_ready=0. load_req -> HDR and clears err.
//   Timeout: in HDR/DATA the counter increments each cycle with no accepted byte and
//     clears on each accepted byte. At count==TIMEOUT -> ERR. Partial data is discarded.
//   Minimum latency: a load of N words takes 4+5N+1 cycles after load_req.
//   load_req in HDR/DATA/WRITE/DONE is ignored (no restart).
//   rst mid-load -> IDLE with core_rst=0. Partial word is discarded. Words already
//     written stay in instruction memory.
//   w_addr is zero-extended from the word index, which spans 0..DEPTH-1.
//   Writes only in WRITE, so at most one write per 5 cycles.
// TESTING
//   1. load_req; bytes 02 00 00 00, 13 00 00 00, 93 00 10 00 at full rate ->
//      two WRITE cycles: (w_addr 0, in_data 0x00000013) and (w_addr 1, in_data 0x00100093).
//      Then done pulse, core_rst 1->0, and fetch IR=0x00000013 after release.
//   2. Header 00 00 00 00 -> no mode=10 cycle; done pulses; back to IDLE.
//   3. Header N=1025 with DEPTH=1024 -> err=1, core_rst=1, no writes.
//      Then a load_req with valid N=1 -> err clears and the load completes.
//   4. TIMEOUT=8: stop after 2 data bytes -> ERR exactly 8 idle cycles after the last byte.
//   5. byte_valid held high continuously -> byte_ready low during every WRITE;
//      every word matches its source bytes and there are no duplicates.
//   6. rst asserted in DATA of word 3; load_req pulsed during busy -> state IDLE, all
//      outputs 0, words 0..2 retained in memory. The mid-load load_req causes no restart.

Source files
------------

// File: rtl/imem_boot_loader.sv
// Boot loader: assembles a little-endian byte stream into words and writes them into the
// fetch stage's instruction memory, holding the core in reset until the load completes.
module imem_boot_loader #(
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned TIMEOUT = 65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_req,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic [1:0]  mode,
  output logic [31:0] w_addr,
  output logic [31:0] in_data,
  output logic        core_rst,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [2:0] {StIdle, StHdr, StData, StWrite, StDone, StErr} state_e;

  state_e          state_q, state_d;
  logic [1:0]      byte_idx_q;
  logic [23:0]     asm_q;  // lower three bytes of the word in progress, newest on top
  logic [31:0]     word_cnt_q;
  logic [IdxW-1:0] word_idx_q;
  logic [31:0]     in_data_q;
  logic [31:0]     tmo_q, tmo_d;
  logic            accept, last_byte, tmo_hit, collecting;
  logic [31:0]     full_word, idx_ext, next_idx;

  assign collecting = (state_q == StHdr) || (state_q == StData);
  assign accept     = byte_valid && byte_ready;
  assign last_byte  = accept && (byte_idx_q == 2'd3);
  assign full_word  = {byte_data, asm_q};
  assign idx_ext    = {{(32-IdxW){1'b0}}, word_idx_q};
  assign next_idx   = idx_ext + 32'd1;

  always_comb begin
    tmo_d = '0;
    if (collecting && !accept) tmo_d = tmo_q + 32'd1;
  end
  assign tmo_hit = (TIMEOUT != 0) && (tmo_d == TIMEOUT);

  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (load_req) state_d = StHdr;
      StHdr: begin
        if (last_byte) begin
          if (full_word == '0)       state_d = StDone;
          else if (full_word > DEPTH) state_d = StErr;
          else                        state_d = StData;
        end else if (tmo_hit) begin
          state_d = StErr;
        end
      end
      StData: begin
        if (last_byte)    state_d = StWrite;
        else if (tmo_hit) state_d = StErr;
      end
      StWrite: state_d = (next_idx == word_cnt_q) ? StDone : StData;
      StDone:  state_d = StIdle;
      StErr:   if (load_req) state_d = StHdr;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      byte_idx_q <= '0;
      asm_q      <= '0;
      word_cnt_q <= '0;
      word_idx_q <= '0;
      in_data_q  <= '0;
      tmo_q      <= '0;
    end else begin
      tmo_q <= tmo_d;
      // Outside HDR/DATA any partial word is dropped.
      if (!collecting) byte_idx_q <= '0;
      else if (accept) begin
        byte_idx_q <= byte_idx_q + 2'd1;
        asm_q      <= {byte_data, asm_q[23:8]};
      end
      if (state_q == StHdr && last_byte) begin
        word_cnt_q <= full_word;
        word_idx_q <= '0;
      end
      if (state_q == StData && last_byte) in_data_q <= full_word;
      if (state_q == StWrite) word_idx_q <= word_idx_q + IdxW'(1);
    end
  end

  always_comb begin
    byte_ready = 1'b0;
    mode       = 2'b00;
    core_rst   = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    unique case (state_q)
      StHdr, StData: begin
        byte_ready = 1'b1;
        core_rst   = 1'b1;
        busy       = 1'b1;
      end
      StWrite: begin
        mode     = 2'b10;
        core_rst = 1'b1;
        busy     = 1'b1;
      end
      StDone: begin
        done     = 1'b1;
        core_rst = 1'b1;
      end
      StErr: begin
        err      = 1'b1;
        core_rst = 1'b1;
      end
      default: ;
    endcase
    w_addr  = idx_ext;
    in_data = in_data_q;
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for imem_boot_loader: random word streams checked against a list of expected
// (address, word) writes and the load latency formula, using a modelled instruction memory.
module tb_imem_boot_loader;
  localparam int unsigned DEPTH   = 1024;
  localparam int unsigned TIMEOUT = 8;

  logic        clk = 1'b0;
  logic        rst, load_req, byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready, core_rst, busy, done, err;
  logic [1:0]  mode;
  logic [31:0] w_addr, in_data;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int write_viol = 0;

  logic [7:0]  stim[$];
  logic [31:0] words[$];
  logic [31:0] wlog_addr[$];
  logic [31:0] wlog_data[$];
  int          done_cyc[$];
  logic        crst_at[int];
  logic [31:0] imem[logic [31:0]];

  imem_boot_loader #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .load_req(load_req), .byte_valid(byte_valid),
    .byte_data(byte_data), .byte_ready(byte_ready), .mode(mode), .w_addr(w_addr),
    .in_data(in_data), .core_rst(core_rst), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Fetch-side view: instruction memory written on mode=10 cycles.
  always @(negedge clk) begin
    if (mode == 2'b10) begin
      wlog_addr.push_back(w_addr);
      wlog_data.push_back(in_data);
      imem[w_addr] = in_data;
      if (byte_ready) write_viol++;
    end
    if (mode[0]) write_viol++;
    if (done) done_cyc.push_back(cyc);
    crst_at[cyc] = core_rst;
  end

  function automatic void push_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) stim.push_back(w[8*i +: 8]);
  endfunction

  function automatic void make_load(input int n);
    logic [31:0] w;
    stim.delete();
    words.delete();
    push_word(32'(n));
    for (int i = 0; i < n; i++) begin
      w = $urandom;
      words.push_back(w);
      push_word(w);
    end
  endfunction

  function automatic void clear_logs();
    wlog_addr.delete();
    wlog_data.delete();
    done_cyc.delete();
    imem.delete();
  endfunction

  task automatic start_load(output int k);
    load_req = 1'b1;
    k = cyc;
    @(posedge clk); #1;
    load_req = 1'b0;
  endtask

  task automatic drive_bytes(input int max_gap);
    int waited;
    int gap;
    while (stim.size() > 0) begin
      gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
      if (gap > 0) begin
        byte_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
      end
      byte_valid = 1'b1;
      byte_data  = stim.pop_front();
      waited     = 0;
      forever begin
        @(negedge clk);
        if (byte_ready) begin @(posedge clk); #1; break; end
        @(posedge clk); #1;
        waited++;
        if (waited > 40) begin
          checks++; failures++;
          $display("FAIL byte_accept: byte_ready stayed %0b for %0d cycles, required 1",
                   byte_ready, waited);
          stim.delete();
          break;
        end
      end
    end
    byte_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (done_cyc.size() == 0 && n < 300) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; load_req = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
    repeat (3) @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({byte_ready, mode, w_addr, in_data, core_rst, busy, done, err} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: rdy=%0b mode=%0b addr=%h data=%h crst=%0b busy=%0b done=%0b err=%0b, required all 0",
               byte_ready, mode, w_addr, in_data, core_rst, busy, done, err);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int k;
    clear_logs();
    stim = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
             8'h93, 8'h00, 8'h10, 8'h00};
    words = '{32'h0000_0013, 32'h0010_0093};
    start_load(k);
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy: got %0b, required 1", busy); end
    drive_bytes(0);
    wait_done();
    checks++;
    if (wlog_addr.size() != 2) begin
      failures++; $display("FAIL basic_count: got %0d writes, required 2", wlog_addr.size());
    end
    for (int i = 0; i < wlog_addr.size() && i < 2; i++) begin
      checks++;
      if (wlog_addr[i] !== 32'(i) || wlog_data[i] !== words[i]) begin
        failures++;
        $display("FAIL basic_write%0d: got addr %h data %h, required addr %h data %h",
                 i, wlog_addr[i], wlog_data[i], i, words[i]);
      end
    end
    checks++;
    if (done_cyc.size() != 1 || done_cyc[0] != k + 15) begin
      failures++;
      $display("FAIL basic_done_cycle: got %0d pulses (first at %0d), required 1 at %0d",
               done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] : -1, k + 15);
    end
    checks++;
    if (crst_at[k + 15] !== 1'b1 || crst_at[k + 16] !== 1'b0) begin
      failures++;
      $display("FAIL basic_core_rst: got %0b then %0b, required 1 then 0",
               crst_at[k + 15], crst_at[k + 16]);
    end
    checks++;
    if (!imem.exists(32'd0) || imem[32'd0] !== 32'h0000_0013) begin
      failures++; $display("FAIL basic_fetch_ir: word 0 missing or wrong, required 00000013");
    end
  endtask

  task automatic test_zero_header();
    int k;
    clear_logs();
    make_load(0);
    start_load(k);
    drive_bytes(0);
    wait_done();
    checks++;
    if (wlog_addr.size() != 0) begin
      failures++; $display("FAIL zero_writes: got %0d, required 0", wlog_addr.size());
    end
    checks++;
    if (done_cyc.size() != 1 || done_cyc[0] != k + 5) begin
      failures++;
      $display("FAIL zero_done: got %0d pulses, required 1 at cycle %0d", done_cyc.size(), k + 5);
    end
    checks++;
    if (busy !== 1'b0 || core_rst !== 1'b0) begin
      failures++; $display("FAIL zero_idle: busy=%0b crst=%0b, required 0 0", busy, core_rst);
    end
  endtask

  task automatic test_oversize();
    int k;
    clear_logs();
    stim.delete();
    push_word(32'd1025);
    start_load(k);
    drive_bytes(0);
    repeat (3) @(negedge clk);
    checks++;
    if (err !== 1'b1 || core_rst !== 1'b1 || byte_ready !== 1'b0 || mode !== 2'b00) begin
      failures++;
      $display("FAIL oversize_err: err=%0b crst=%0b rdy=%0b mode=%0b, required 1 1 0 00",
               err, core_rst, byte_ready, mode);
    end
    checks++;
    if (wlog_addr.size() != 0) begin
      failures++; $display("FAIL oversize_writes: got %0d, required 0", wlog_addr.size());
    end
    @(posedge clk); #1;
    make_load(1);
    start_load(k);
    @(negedge clk);
    checks++;
    if (err !== 1'b0 || busy !== 1'b1) begin
      failures++; $display("FAIL oversize_reload: err=%0b busy=%0b, required 0 1", err, busy);
    end
    @(posedge clk); #1;
    drive_bytes(0);
    wait_done();
    checks++;
    if (wlog_addr.size() != 1 || wlog_data[0] !== words[0] || done_cyc.size() != 1) begin
      failures++;
      $display("FAIL oversize_recover: got %0d writes and %0d done pulses, required 1 and 1",
               wlog_addr.size(), done_cyc.size());
    end
  endtask

  task automatic test_timeout();
    int k, n, full;
    clear_logs();
    n    = $urandom_range(2, 4);
    full = $urandom_range(0, n - 1);
    make_load(n);
    while (stim.size() > 4 + 4 * full + 2) void'(stim.pop_back());
    start_load(k);
    drive_bytes(0);
    repeat (7) @(posedge clk);
    @(negedge clk);
    checks++;
    if (err !== 1'b0 || busy !== 1'b1) begin
      failures++; $display("FAIL timeout_early: after 7 idle err=%0b busy=%0b, required 0 1", err, busy);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (err !== 1'b1 || core_rst !== 1'b1 || byte_ready !== 1'b0) begin
      failures++;
      $display("FAIL timeout_err: after 8 idle err=%0b crst=%0b rdy=%0b, required 1 1 0",
               err, core_rst, byte_ready);
    end
    checks++;
    if (wlog_addr.size() != full || done_cyc.size() != 0) begin
      failures++;
      $display("FAIL timeout_writes: got %0d writes %0d done, required %0d writes 0 done",
               wlog_addr.size(), done_cyc.size(), full);
    end
    for (int i = 0; i < wlog_addr.size() && i < full; i++) begin
      checks++;
      if (wlog_addr[i] !== 32'(i) || wlog_data[i] !== words[i]) begin
        failures++;
        $display("FAIL timeout_word%0d: got %h@%h, required %h@%h",
                 i, wlog_data[i], wlog_addr[i], words[i], i);
      end
    end
    @(posedge clk); #1;
  endtask

  // Bytes offered every cycle, including through WRITE stalls.
  task automatic test_back_to_back();
    int k, n;
    for (int it = 0; it < 4; it++) begin
      clear_logs();
      write_viol = 0;
      n = $urandom_range(1, 8);
      make_load(n);
      start_load(k);
      drive_bytes(0);
      wait_done();
      checks++;
      if (write_viol != 0) begin
        failures++; $display("FAIL b2b_ready_in_write: got %0d violations, required 0", write_viol);
      end
      checks++;
      if (done_cyc.size() != 1 || done_cyc[0] != k + 5 + 5 * n) begin
        failures++;
        $display("FAIL b2b_latency n=%0d: got %0d pulses (first %0d), required 1 at %0d",
                 n, done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] : -1, k + 5 + 5 * n);
      end
      checks++;
      if (wlog_addr.size() != n) begin
        failures++; $display("FAIL b2b_count: got %0d writes, required %0d", wlog_addr.size(), n);
      end
      for (int i = 0; i < wlog_addr.size() && i < n; i++) begin
        checks++;
        if (wlog_addr[i] !== 32'(i) || wlog_data[i] !== words[i]) begin
          failures++;
          $display("FAIL b2b_word%0d: got %h@%h, required %h@%h",
                   i, wlog_data[i], wlog_addr[i], words[i], i);
        end
      end
    end
  endtask

  task automatic test_random_gaps();
    int k, n;
    for (int it = 0; it < 4; it++) begin
      clear_logs();
      n = $urandom_range(1, 5);
      make_load(n);
      start_load(k);
      drive_bytes(4);
      wait_done();
      checks++;
      if (done_cyc.size() != 1 || wlog_addr.size() != n || err !== 1'b0) begin
        failures++;
        $display("FAIL gaps_summary n=%0d: got %0d done %0d writes err=%0b, required 1 %0d 0",
                 n, done_cyc.size(), wlog_addr.size(), err, n);
      end
      for (int i = 0; i < n; i++) begin
        checks++;
        if (!imem.exists(32'(i)) || imem[32'(i)] !== words[i]) begin
          failures++; $display("FAIL gaps_mem%0d: word missing or wrong, required %h", i, words[i]);
        end
      end
    end
  endtask

  task automatic test_rst_mid_load();
    int k;
    logic [7:0] all_b[$];
    clear_logs();
    make_load(5);
    all_b = stim;
    stim  = all_b[0:7];
    start_load(k);
    drive_bytes(0);
    load_req = 1'b1;
    @(posedge clk); #1;
    load_req = 1'b0;
    stim = all_b[8:17];
    drive_bytes(0);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || byte_ready !== 1'b1) begin
      failures++; $display("FAIL midload_state: busy=%0b rdy=%0b, required 1 1", busy, byte_ready);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({byte_ready, mode, w_addr, in_data, core_rst, busy, done, err} !== '0) begin
      failures++;
      $display("FAIL midload_reset: rdy=%0b mode=%0b addr=%h data=%h crst=%0b busy=%0b done=%0b err=%0b, required all 0",
               byte_ready, mode, w_addr, in_data, core_rst, busy, done, err);
    end
    checks++;
    if (wlog_addr.size() != 3 || imem.exists(32'd3)) begin
      failures++; $display("FAIL midload_writes: got %0d writes, required 3", wlog_addr.size());
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (!imem.exists(32'(i)) || imem[32'(i)] !== words[i]) begin
        failures++; $display("FAIL midload_mem%0d: word missing or wrong, required %h", i, words[i]);
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; load_req = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
    test_reset();
    test_basic();
    test_zero_header();
    test_oversize();
    test_timeout();
    test_back_to_back();
    test_random_gaps();
    test_rst_mid_load();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
